uart_cmd_ctrl: RTL and testbench

Command front end between the UART byte receiver/transmitter and the register file. It assembles framed host commands from received bytes, then issues single-cycle write or read strobes with address and data to the register file. It returns the read data, or a write acknowledge, as bytes to the UART transmitter. Malformed or stalled frames are discarded and flagged.

---
 rtl/uart_cmd_ctrl_pkg.sv | 22 ++
 rtl/uart_cmd_ctrl_shifter.sv | 63 ++++++
 rtl/uart_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and FSM state type for the UART command front end.
// Command codes, acknowledge byte and strobe bit positions live here.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam int WR_BIT = 1;
  localparam int RD_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_WAIT_RESP,
    ST_TX_SEND
  } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_shifter.sv
// Response serializer: loads 1 or 4 bytes and hands them MSB first to the
// transmitter over a valid/ready handshake, with a gap cycle between bytes.
module cmd_resp_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        len4,
  input  logic [31:0] load_data,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        done
);

  logic [31:0] buf_q, buf_d;
  logic [1:0]  rem_q, rem_d;
  logic        vld_q, vld_d;
  logic        pend_q, pend_d;

  always_comb begin
    buf_d  = buf_q;
    rem_d  = rem_q;
    vld_d  = vld_q;
    pend_d = pend_q;
    done   = 1'b0;
    if (load) begin
      buf_d  = load_data;
      rem_d  = len4 ? 2'd3 : 2'd0;
      vld_d  = 1'b1;
      pend_d = 1'b0;
    end else if (vld_q && tx_rdy) begin
      vld_d = 1'b0;
      if (rem_q == 2'd0) begin
        done = 1'b1;
      end else begin
        rem_d  = rem_q - 2'd1;
        buf_d  = {buf_q[23:0], 8'h00};
        pend_d = 1'b1;
      end
    end else if (pend_q) begin
      vld_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= 32'h0;
      rem_q  <= 2'd0;
      vld_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      rem_q  <= rem_d;
      vld_q  <= vld_d;
      pend_q <= pend_d;
    end
  end

  assign tx_data = buf_q[31:24];
  assign tx_vld  = vld_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command front end: assembles W/R frames from UART bytes, strobes the
// register file, and returns read data or a write ack to the transmitter.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int RESP_WAIT   = 8
) (
  input  logic        CLK_100M,
  input  logic        SYS_RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VLD,
  output logic [7:0]  TX_DATA,
  output logic        TX_VLD,
  input  logic        TX_RDY,
  output logic [1:0]  UART_STATE,
  output logic [7:0]  UART_ADDR,
  output logic [31:0] UART_DATA,
  input  logic [1:0]  REG_STATE,
  input  logic [31:0] REG_DATA,
  output logic        CMD_BUSY,
  output logic        CMD_ERR
);

  // One timer serves both the inter-byte and the response timeout.
  localparam int TW = $clog2(TIMEOUT_CYC + RESP_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] RSP_LAST = TW'(RESP_WAIT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_rd_q, is_rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic          ld;
  logic          ld_len4;
  logic [31:0]   ld_data;
  logic          tx_done;
  logic          resp_hit;

  assign resp_hit = is_rd_q ? REG_STATE[RD_BIT] : REG_STATE[WR_BIT];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    ld      = 1'b0;
    ld_len4 = 1'b0;
    ld_data = 32'h0;
    unique case (state_q)
      ST_IDLE: begin
        if (RX_VLD) begin
          if (RX_DATA == CMD_WR || RX_DATA == CMD_RD) begin
            is_rd_d = (RX_DATA == CMD_RD);
            tmr_d   = '0;
            state_d = ST_GET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (RX_VLD) begin
          addr_d  = RX_DATA;
          tmr_d   = '0;
          cnt_d   = 2'd0;
          state_d = is_rd_q ? ST_RD_ISSUE : ST_GET_DATA;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (RX_VLD) begin
          data_d = {data_q[23:0], RX_DATA};
          tmr_d  = '0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_WR_ISSUE;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WR_ISSUE, ST_RD_ISSUE: begin
        err_d   = RX_VLD;
        tmr_d   = '0;
        state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        err_d = RX_VLD;
        if (resp_hit) begin
          ld      = 1'b1;
          ld_len4 = is_rd_q;
          ld_data = is_rd_q ? REG_DATA : {ACK_BYTE, 24'h0};
          state_d = ST_TX_SEND;
        end else if (tmr_q == RSP_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_TX_SEND: begin
        err_d = RX_VLD;
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      cnt_q   <= 2'd0;
      is_rd_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  cmd_resp_shifter u_shifter (
    .clk       (CLK_100M),
    .rst       (SYS_RST),
    .load      (ld),
    .len4      (ld_len4),
    .load_data (ld_data),
    .tx_rdy    (TX_RDY),
    .tx_data   (TX_DATA),
    .tx_vld    (TX_VLD),
    .done      (tx_done)
  );

  assign UART_STATE[WR_BIT] = (state_q == ST_WR_ISSUE);
  assign UART_STATE[RD_BIT] = (state_q == ST_RD_ISSUE);
  assign UART_ADDR          = addr_q;
  assign UART_DATA          = data_q;
  assign CMD_BUSY           = (state_q != ST_IDLE);
  assign CMD_ERR            = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write/read frames, TX stall,
// bad command, timeouts, dropped bytes and asynchronous reset.
module tb_uart_cmd_ctrl;

  logic        CLK_100M = 1'b0;
  logic        SYS_RST;
  logic [7:0]  RX_DATA;
  logic        RX_VLD;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic [1:0]  UART_STATE;
  logic [7:0]  UART_ADDR;
  logic [31:0] UART_DATA;
  logic [1:0]  REG_STATE;
  logic [31:0] REG_DATA;
  logic        CMD_BUSY;
  logic        CMD_ERR;

  int total = 0;
  int bad   = 0;
  int wr_stb = 0;
  int rd_stb = 0;
  int errs   = 0;
  int tx_hs  = 0;
  logic [7:0] rx_bytes [0:7];
  int rx_n;

  uart_cmd_ctrl #(.TIMEOUT_CYC(100), .RESP_WAIT(8)) dut (
    .CLK_100M   (CLK_100M),
    .SYS_RST    (SYS_RST),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_RDY     (TX_RDY),
    .UART_STATE (UART_STATE),
    .UART_ADDR  (UART_ADDR),
    .UART_DATA  (UART_DATA),
    .REG_STATE  (REG_STATE),
    .REG_DATA   (REG_DATA),
    .CMD_BUSY   (CMD_BUSY),
    .CMD_ERR    (CMD_ERR)
  );

  always #5 CLK_100M = ~CLK_100M;

  always @(posedge CLK_100M) begin
    if (!SYS_RST) begin
      if (UART_STATE[1]) wr_stb++;
      if (UART_STATE[0]) rd_stb++;
      if (CMD_ERR) errs++;
      if (TX_VLD && TX_RDY) tx_hs++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK_100M);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VLD  = 1'b1;
    step();
    RX_VLD  = 1'b0;
  endtask

  task automatic collect_tx(input int n, input int budget);
    rx_n = 0;
    for (int i = 0; i < budget; i++) begin
      if (TX_VLD && TX_RDY && rx_n < 8) begin
        rx_bytes[rx_n] = TX_DATA;
        rx_n++;
      end
      if (rx_n >= n) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    SYS_RST = 1'b1; RX_DATA = 8'h00; RX_VLD = 1'b0; TX_RDY = 1'b1;
    REG_STATE = 2'b00; REG_DATA = 32'h0;
    repeat (3) step();
    total++; if (UART_STATE !== 2'b00) begin bad++; $display("FAIL rst_state got=%b want=00", UART_STATE); end
    total++; if (UART_ADDR !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", UART_ADDR); end
    total++; if (UART_DATA !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", UART_DATA); end
    total++; if (TX_VLD !== 1'b0 || TX_DATA !== 8'h00) begin bad++; $display("FAIL rst_tx got=%b/%h want=0/00", TX_VLD, TX_DATA); end
    total++; if (CMD_BUSY !== 1'b0 || CMD_ERR !== 1'b0) begin bad++; $display("FAIL rst_busy_err got=%b%b want=00", CMD_BUSY, CMD_ERR); end
    SYS_RST = 1'b0;
    step();
  endtask

  task automatic test_write();
    int w0 = wr_stb;
    send_byte(8'h57); send_byte(8'h08);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    total++; if (UART_STATE !== 2'b10) begin bad++; $display("FAIL wr_strobe got=%b want=10", UART_STATE); end
    total++; if (UART_ADDR !== 8'h08) begin bad++; $display("FAIL wr_addr got=%h want=08", UART_ADDR); end
    total++; if (UART_DATA !== 32'h1) begin bad++; $display("FAIL wr_data got=%h want=00000001", UART_DATA); end
    step();
    total++; if (UART_STATE !== 2'b00) begin bad++; $display("FAIL wr_strobe_len got=%b want=00", UART_STATE); end
    REG_STATE = 2'b10;
    step();
    REG_STATE = 2'b00;
    total++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h4B) begin bad++; $display("FAIL wr_ack_time got=%b/%h want=1/4b", TX_VLD, TX_DATA); end
    collect_tx(1, 20);
    total++; if (rx_n !== 1 || rx_bytes[0] !== 8'h4B) begin bad++; $display("FAIL wr_ack got n=%0d b=%h want n=1 b=4b", rx_n, rx_bytes[0]); end
    total++; if (CMD_BUSY !== 1'b0 || wr_stb - w0 !== 1) begin bad++; $display("FAIL wr_end got busy=%b stb=%0d want 0/1", CMD_BUSY, wr_stb - w0); end
  endtask

  task automatic test_read_stall();
    logic stalled = 1'b0;
    send_byte(8'h52); send_byte(8'h00);
    total++; if (UART_STATE !== 2'b01 || UART_ADDR !== 8'h00) begin bad++; $display("FAIL rd_strobe got=%b/%h want=01/00", UART_STATE, UART_ADDR); end
    step();
    REG_STATE = 2'b01; REG_DATA = 32'h12345678;
    step();
    REG_STATE = 2'b00; REG_DATA = 32'hDEADBEEF;
    total++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h12) begin bad++; $display("FAIL rd_first_time got=%b/%h want=1/12", TX_VLD, TX_DATA); end
    total++; if (UART_DATA !== 32'h1) begin bad++; $display("FAIL rd_keeps_data got=%h want=00000001", UART_DATA); end
    rx_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (TX_VLD && rx_n == 1 && !stalled) begin
        TX_RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          total++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h34) begin bad++; $display("FAIL rd_stall_hold got=%b/%h want=1/34", TX_VLD, TX_DATA); end
        end
        stalled = 1'b1;
        TX_RDY = 1'b1;
      end
      if (TX_VLD && TX_RDY && rx_n < 8) begin rx_bytes[rx_n] = TX_DATA; rx_n++; end
      if (rx_n >= 4) break;
      step();
    end
    step();
    total++; if (rx_n !== 4 || {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'h12345678) begin
      bad++; $display("FAIL rd_bytes got n=%0d %h%h%h%h want 12345678", rx_n, rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]);
    end
    total++; if (CMD_BUSY !== 1'b0) begin bad++; $display("FAIL rd_end_busy got=%b want=0", CMD_BUSY); end
  endtask

  task automatic test_bad_cmd();
    int r0 = rd_stb;
    int w0 = wr_stb;
    send_byte(8'hA5);
    total++; if (CMD_ERR !== 1'b1 || CMD_BUSY !== 1'b0) begin bad++; $display("FAIL bad_cmd_err got err=%b busy=%b want 1/0", CMD_ERR, CMD_BUSY); end
    step();
    total++; if (CMD_ERR !== 1'b0 || rd_stb != r0 || wr_stb != w0) begin bad++; $display("FAIL bad_cmd_pulse got err=%b stb=%0d want 0/0", CMD_ERR, rd_stb - r0 + wr_stb - w0); end
    send_byte(8'h52); send_byte(8'h04);
    total++; if (UART_STATE !== 2'b01 || UART_ADDR !== 8'h04) begin bad++; $display("FAIL bad_then_rd got=%b/%h want=01/04", UART_STATE, UART_ADDR); end
    step();
    REG_STATE = 2'b01; REG_DATA = 32'hA1B2C3D4;
    step();
    REG_STATE = 2'b00;
    collect_tx(4, 40);
    total++; if (rx_n !== 4 || {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL bad_then_rd_bytes got n=%0d %h%h%h%h want a1b2c3d4", rx_n, rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]);
    end
  endtask

  task automatic test_timeout();
    int w0 = wr_stb;
    int e0;
    int k = 0;
    send_byte(8'h57); send_byte(8'h0C); send_byte(8'h00);
    while (CMD_ERR !== 1'b1 && k < 300) begin step(); k++; end
    total++; if (k != 100) begin bad++; $display("FAIL tmo_cycles got=%0d want=100", k); end
    total++; if (CMD_BUSY !== 1'b0 || wr_stb != w0) begin bad++; $display("FAIL tmo_idle got busy=%b stb=%0d want 0/0", CMD_BUSY, wr_stb - w0); end
    step();
    e0 = errs;
    send_byte(8'h57);
    repeat (99) step();
    send_byte(8'h0E);
    total++; if (CMD_ERR !== 1'b0 || CMD_BUSY !== 1'b1 || UART_ADDR !== 8'h0E) begin
      bad++; $display("FAIL tmo_edge_accept got err=%b busy=%b addr=%h want 0/1/0e", CMD_ERR, CMD_BUSY, UART_ADDR);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    total++; if (UART_STATE !== 2'b10 || UART_DATA !== 32'h5) begin bad++; $display("FAIL tmo_edge_wr got=%b/%h want=10/00000005", UART_STATE, UART_DATA); end
    step();
    REG_STATE = 2'b10;
    step();
    REG_STATE = 2'b00;
    collect_tx(1, 20);
    total++; if (rx_n !== 1 || rx_bytes[0] !== 8'h4B || errs != e0) begin bad++; $display("FAIL tmo_edge_ack got n=%0d b=%h errs=%0d want 1/4b/0", rx_n, rx_bytes[0], errs - e0); end
  endtask

  task automatic test_resp_timeout_drop();
    int t0 = tx_hs;
    int k = 0;
    send_byte(8'h52); send_byte(8'h20);
    while (CMD_ERR !== 1'b1 && k < 50) begin step(); k++; end
    total++; if (k != 9) begin bad++; $display("FAIL rsp_tmo_cycles got=%0d want=9", k); end
    total++; if (CMD_BUSY !== 1'b0 || TX_VLD !== 1'b0 || tx_hs != t0) begin bad++; $display("FAIL rsp_tmo_no_tx got busy=%b vld=%b hs=%0d want 0/0/0", CMD_BUSY, TX_VLD, tx_hs - t0); end
    step();
    send_byte(8'h57); send_byte(8'h40);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    step();
    REG_STATE = 2'b10; TX_RDY = 1'b0;
    step();
    REG_STATE = 2'b00;
    send_byte(8'h99);
    total++; if (CMD_ERR !== 1'b1 || TX_VLD !== 1'b1 || TX_DATA !== 8'h4B || CMD_BUSY !== 1'b1) begin
      bad++; $display("FAIL drop_in_tx got err=%b vld=%b d=%h busy=%b want 1/1/4b/1", CMD_ERR, TX_VLD, TX_DATA, CMD_BUSY);
    end
    TX_RDY = 1'b1;
    collect_tx(1, 20);
    total++; if (rx_n !== 1 || rx_bytes[0] !== 8'h4B || CMD_BUSY !== 1'b0) begin bad++; $display("FAIL drop_tx_cont got n=%0d b=%h busy=%b want 1/4b/0", rx_n, rx_bytes[0], CMD_BUSY); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h57); send_byte(8'h33); send_byte(8'hAA);
    #2;
    SYS_RST = 1'b1;
    #1;
    total++; if (UART_ADDR !== 8'h00 || UART_DATA !== 32'h0) begin bad++; $display("FAIL rst_mid_regs got=%h/%h want=00/0", UART_ADDR, UART_DATA); end
    total++; if (CMD_BUSY !== 1'b0 || TX_VLD !== 1'b0 || UART_STATE !== 2'b00) begin bad++; $display("FAIL rst_mid_ctl got busy=%b vld=%b st=%b want 0/0/00", CMD_BUSY, TX_VLD, UART_STATE); end
    step();
    SYS_RST = 1'b0;
    step();
    send_byte(8'h57); send_byte(8'h44);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    total++; if (UART_STATE !== 2'b10 || UART_ADDR !== 8'h44 || UART_DATA !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rst_after_wr got=%b/%h/%h want=10/44/deadbeef", UART_STATE, UART_ADDR, UART_DATA);
    end
    step();
    REG_STATE = 2'b10;
    step();
    REG_STATE = 2'b00;
    collect_tx(1, 20);
    total++; if (rx_n !== 1 || rx_bytes[0] !== 8'h4B) begin bad++; $display("FAIL rst_after_ack got n=%0d b=%h want 1/4b", rx_n, rx_bytes[0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_bad_cmd();
    test_timeout();
    test_resp_timeout_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
